bus_interconnect: RTL

Parametrised, registered memory-mapped interconnect between the RISC-V core's data port and its peripherals (RAM, keyboard, switches, LEDs, 7-segment, timer, BCD, UART, SPI, menu ROM). It decodes a mask/base address map into one-hot select and write strobes, waits for a per-slave acknowledge, and returns registered read data with a ready/error handshake. Unmapped addresses and slaves that never acknowledge produce a bus error.

---
 rtl/bus_pkg.sv | 60 ++++++
 rtl/bus_interconnect_if.sv | 34 +++
 rtl/bus_interconnect_decoder.sv | 35 +++
 rtl/bus_interconnect.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and the default memory map for the core-to-peripheral interconnect.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int N_SLAVES_DEF = 12;
  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int TIMEOUT_DEF  = 15;

  // Slave port assignment of the current memory map
  localparam int SLV_RAM       = 0;
  localparam int SLV_KBD       = 1;
  localparam int SLV_SW        = 2;
  localparam int SLV_LED       = 3;
  localparam int SLV_SEG7      = 4;
  localparam int SLV_TIMER     = 5;
  localparam int SLV_BCD       = 6;
  localparam int SLV_UART_CTRL = 7;
  localparam int SLV_UART_DATA = 8;
  localparam int SLV_SPI_CTRL  = 9;
  localparam int SLV_SPI_DATA  = 10;
  localparam int SLV_MENU_ROM  = 11;

  // Listed from slave 11 down to slave 0
  localparam logic [N_SLAVES_DEF-1:0][ADDR_W_DEF-1:0] DEFAULT_BASE = {
    32'h0002_0000,  // menu ROM
    32'h0001_0074,  // SPI data
    32'h0001_0070,  // SPI control
    32'h0001_0064,  // UART data
    32'h0001_0060,  // UART control
    32'h0001_0050,  // BCD
    32'h0001_0040,  // timer
    32'h0001_0030,  // 7-segment
    32'h0001_0020,  // LEDs
    32'h0001_0010,  // switches
    32'h0001_0000,  // keyboard
    32'h0000_0000   // RAM
  };

  localparam logic [N_SLAVES_DEF-1:0][ADDR_W_DEF-1:0] DEFAULT_MASK = {
    32'hFFFF_F000,
    32'hFFFF_FFFC,
    32'hFFFF_FFFC,
    32'hFFFF_FFFC,
    32'hFFFF_FFFC,
    32'hFFFF_FFF0,
    32'hFFFF_FFF0,
    32'hFFFF_FFF0,
    32'hFFFF_FFF0,
    32'hFFFF_FFF0,
    32'hFFFF_FFF0,
    32'hFFFF_0000
  };

endpackage

// File: rtl/bus_interconnect_if.sv
// Core-side request/response and peripheral-side select/strobe/data bundle.
interface bus_interconnect_if
  import bus_pkg::*;
#(
  parameter int N_SLAVES = N_SLAVES_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
);
  logic                       req_i;
  logic                       we_i;
  logic [ADDR_W-1:0]          address_i;
  logic [DATA_W-1:0]          wdata_i;
  logic                       ready_o;
  logic [DATA_W-1:0]          d_o;
  logic                       err_o;
  logic [N_SLAVES-1:0]        sel_o;
  logic [N_SLAVES-1:0]        we_o;
  logic [ADDR_W-1:0]          addr_o;
  logic [DATA_W-1:0]          wdata_o;
  logic [N_SLAVES*DATA_W-1:0] rdata_i;
  logic [N_SLAVES-1:0]        ack_i;

  // Interconnect view: takes the core request and peripheral replies
  modport slave (
    input  req_i, we_i, address_i, wdata_i, rdata_i, ack_i,
    output ready_o, d_o, err_o, sel_o, we_o, addr_o, wdata_o
  );

  // Environment view: the core plus the peripherals around the interconnect
  modport master (
    output req_i, we_i, address_i, wdata_i, rdata_i, ack_i,
    input  ready_o, d_o, err_o, sel_o, we_o, addr_o, wdata_o
  );
endinterface

// File: rtl/bus_interconnect_decoder.sv
// Mask/base address decoder; the lowest matching slave index wins on overlap.
module addr_decoder
  import bus_pkg::*;
#(
  parameter int N_SLAVES = N_SLAVES_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] BASE = DEFAULT_BASE,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] MASK = DEFAULT_MASK
) (
  input  logic [ADDR_W-1:0] address,
  output logic              hit,
  output logic [IDX_W-1:0]  index
);

  logic [N_SLAVES-1:0] match_s;

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_match
    assign match_s[g] = ((address & MASK[g]) == BASE[g]);
  end

  // Scan from the top so the lowest matching index is the one left standing
  always_comb begin
    hit   = |match_s;
    index = {IDX_W{1'b0}};
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (match_s[i]) begin
        index = IDX_W'(i);
      end else begin
        index = index;
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// Registered single-outstanding interconnect: decode, wait for ack or timeout, respond.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int N_SLAVES = N_SLAVES_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] BASE = DEFAULT_BASE,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] MASK = DEFAULT_MASK
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  bus_interconnect_if.slave bus
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state_r, next_state_s;
  logic                dec_hit_s;
  logic [IDX_W-1:0]    dec_idx_s, idx_r, idx_nxt_s;
  logic [N_SLAVES-1:0] dec_hot_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic                wr_r, wr_nxt_s;
  logic                ready_r, ready_nxt_s;
  logic                err_r, err_nxt_s;
  logic [DATA_W-1:0]   d_r, d_nxt_s;
  logic [N_SLAVES-1:0] sel_r, sel_nxt_s;
  logic [N_SLAVES-1:0] we_r, we_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [DATA_W-1:0]   wdata_r, wdata_nxt_s;
  logic [DATA_W-1:0]   rdata_arr_s [N_SLAVES];
  logic                ack_sel_s;
  logic                timeout_s;

  addr_decoder #(
    .N_SLAVES (N_SLAVES),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W),
    .BASE     (BASE),
    .MASK     (MASK)
  ) u_dec (
    .address (bus.address_i),
    .hit     (dec_hit_s),
    .index   (dec_idx_s)
  );

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_rdata
    assign rdata_arr_s[g] = bus.rdata_i[g*DATA_W +: DATA_W];
  end

  assign dec_hot_s = N_SLAVES'(1'b1) << dec_idx_s;
  // Only the latched slave's acknowledge can end a transaction
  assign ack_sel_s = bus.ack_i[idx_r];
  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req_i) begin
          next_state_s = dec_hit_s ? WAIT : RESP;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (ack_sel_s || timeout_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; d/err change only on completion
  always_comb begin
    ready_nxt_s = 1'b0;
    err_nxt_s   = err_r;
    d_nxt_s     = d_r;
    sel_nxt_s   = {N_SLAVES{1'b0}};
    we_nxt_s    = {N_SLAVES{1'b0}};
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    wr_nxt_s    = wr_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.req_i) begin
          addr_nxt_s  = bus.address_i;
          wdata_nxt_s = bus.wdata_i;
          wr_nxt_s    = bus.we_i;
          if (dec_hit_s) begin
            idx_nxt_s = dec_idx_s;
            sel_nxt_s = dec_hot_s;
            we_nxt_s  = bus.we_i ? dec_hot_s : {N_SLAVES{1'b0}};
            cnt_nxt_s = {CNT_W{1'b0}};
          end else begin
            ready_nxt_s = 1'b1;
            err_nxt_s   = 1'b1;
            d_nxt_s     = {DATA_W{1'b0}};
          end
        end else begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end
      end
      WAIT: begin
        if (ack_sel_s) begin
          ready_nxt_s = 1'b1;
          err_nxt_s   = 1'b0;
          d_nxt_s     = wr_r ? {DATA_W{1'b0}} : rdata_arr_s[idx_r];
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (timeout_s) begin
          ready_nxt_s = 1'b1;
          err_nxt_s   = 1'b1;
          d_nxt_s     = {DATA_W{1'b0}};
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          sel_nxt_s = sel_r;
          cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      RESP:    ready_nxt_s = 1'b0;
      default: ready_nxt_s = 1'b0;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      d_r     <= {DATA_W{1'b0}};
      sel_r   <= {N_SLAVES{1'b0}};
      we_r    <= {N_SLAVES{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      wr_r    <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      ready_r <= ready_nxt_s;
      err_r   <= err_nxt_s;
      d_r     <= d_nxt_s;
      sel_r   <= sel_nxt_s;
      we_r    <= we_nxt_s;
      addr_r  <= addr_nxt_s;
      wdata_r <= wdata_nxt_s;
      wr_r    <= wr_nxt_s;
      idx_r   <= idx_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign bus.ready_o = ready_r;
  assign bus.err_o   = err_r;
  assign bus.d_o     = d_r;
  assign bus.sel_o   = sel_r;
  assign bus.we_o    = we_r;
  assign bus.addr_o  = addr_r;
  assign bus.wdata_o = wdata_r;

endmodule
